// File: rtl/dbg_hex_printer.sv
// ============================================================================
//  Module   : dbg_hex_printer
//  Brief    : Formats one value as an ASCII hex line into the debug FIFO.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dbg_hex_printer #(
    parameter int DATA_WIDTH = 32,
    parameter int PREFIX_EN  = 1,
    parameter int NEWLINE_EN = 1,
    parameter int UPPERCASE  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  busy,
    output logic                  done,
    output logic                  wr,
    output logic [7:0]            msg,
    input  logic                  full
);

    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PFX0  = 3'd1,
        S_PFX1  = 3'd2,
        S_DIGIT = 3'd3,
        S_CR    = 3'd4,
        S_LF    = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sv_q, sv_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            nibble_w;
    logic [7:0]            digit_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sv_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sv_q    <= sv_d;
            cnt_q   <= cnt_d;
        end
    end

    // Most-significant nibble is selected first as the counter runs down.
    always_comb begin
        nibble_w = 4'h0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                nibble_w = sv_q[4*k +: 4];
            end
        end
    end

    always_comb begin
        if (nibble_w < 4'd10) begin
            digit_w = 8'h30 + {4'h0, nibble_w};
        end else if (UPPERCASE != 0) begin
            digit_w = 8'h37 + {4'h0, nibble_w};
        end else begin
            digit_w = 8'h57 + {4'h0, nibble_w};
        end
    end

    always_comb begin
        state_d = state_q;
        sv_d    = sv_q;
        cnt_d   = cnt_q;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        wr      = 1'b0;
        msg     = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sv_d  = value;
                    cnt_d = CNT_W'(NIBBLES - 1);
                    if (PREFIX_EN != 0) begin
                        state_d = S_PFX0;
                    end else begin
                        state_d = S_DIGIT;
                    end
                end
            end
            S_PFX0: begin
                msg = 8'h30;
                wr  = !full;
                if (!full) begin
                    state_d = S_PFX1;
                end
            end
            S_PFX1: begin
                msg = 8'h78;
                wr  = !full;
                if (!full) begin
                    state_d = S_DIGIT;
                end
            end
            S_DIGIT: begin
                msg = digit_w;
                wr  = !full;
                if (!full) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (NEWLINE_EN != 0) begin
                        state_d = S_CR;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_CR: begin
                msg = 8'h0D;
                wr  = !full;
                if (!full) begin
                    state_d = S_LF;
                end
            end
            S_LF: begin
                msg = 8'h0A;
                wr  = !full;
                if (!full) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_dbg_hex_printer.sv
// ============================================================================
//  Module   : tb_dbg_hex_printer
//  Brief    : Line-level reference model bench for three printer configurations.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dbg_hex_printer;

    typedef logic [7:0] bq_t[$];

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        full  = 1'b0;
    logic [31:0] value = '0;
    logic [2:0]  busy, done, wr;
    logic [7:0]  msg [3];

    int vectors     = 0;
    int miscompares = 0;

    // Instance configs: 0 = defaults, 1 = lowercase, 2 = 8-bit bare digits.
    int pfx_a[3] = '{1, 1, 0};
    int nl_a [3] = '{1, 1, 0};
    int nib_a[3] = '{8, 8, 2};
    int up_a [3] = '{1, 0, 1};

    string line_s[3];
    int    pos_m [3];
    int    mode_m[3];   // 0 idle, 1 emitting, 2 finishing
    bq_t   cap0, cap1, cap2;
    int    run0 = 0;

    always #5 clk = ~clk;

    dbg_hex_printer u_def (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy[0]), .done(done[0]), .wr(wr[0]), .msg(msg[0]), .full(full)
    );

    dbg_hex_printer #(.UPPERCASE(0)) u_lc (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy[1]), .done(done[1]), .wr(wr[1]), .msg(msg[1]), .full(full)
    );

    dbg_hex_printer #(.DATA_WIDTH(8), .PREFIX_EN(0), .NEWLINE_EN(0)) u_b8 (
        .clk(clk), .reset(reset), .start(start), .value(value[7:0]),
        .busy(busy[2]), .done(done[2]), .wr(wr[2]), .msg(msg[2]), .full(full)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic string fmt(input int i, input logic [31:0] v);
        string s;
        int    n;
        int    c;
        s = (pfx_a[i] != 0) ? "0x" : "";
        for (int k = nib_a[i] - 1; k >= 0; k--) begin
            n = int'((v >> (4 * k)) & 32'hF);
            c = (n < 10) ? 48 + n : ((up_a[i] != 0) ? 65 : 97) + n - 10;
            s = $sformatf("%s%c", s, c[7:0]);
        end
        if (nl_a[i] != 0) s = {s, "\r\n"};
        return s;
    endfunction

    task automatic chk_str(input string nm, input bq_t q, input int base, input string s);
        logic [31:0] a;
        chk({nm, "_len"}, 32'(q.size() - base), 32'(s.len()));
        for (int k = 0; k < s.len(); k++) begin
            a = 'x;
            if (base + k < q.size()) a = 32'(q[base + k]);
            chk(nm, a, 32'(s[k]));
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 3'b000 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic pulse(input logic [31:0] v);
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Compare just before each rising edge, then advance the line model on the edge.
    initial begin
        int exp_msg;
        for (int i = 0; i < 3; i++) begin
            mode_m[i] = 0;
            pos_m[i]  = 0;
            line_s[i] = "";
        end
        forever begin
            @(negedge clk);
            #4;
            if (!reset) for (int i = 0; i < 3; i++) mode_m[i] = 0;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy%0d", i), 32'(busy[i]), (mode_m[i] != 0) ? 1 : 0);
                chk($sformatf("done%0d", i), 32'(done[i]), (mode_m[i] == 2) ? 1 : 0);
                chk($sformatf("wr%0d", i), 32'(wr[i]), (mode_m[i] == 1 && !full) ? 1 : 0);
                if (mode_m[i] == 1 || !reset) begin
                    exp_msg = (mode_m[i] == 1) ? int'(line_s[i][pos_m[i]]) : 0;
                    chk($sformatf("msg%0d", i), 32'(msg[i]), exp_msg);
                end
            end
            if (reset && wr[0] === 1'b1) cap0.push_back(msg[0]);
            if (reset && wr[1] === 1'b1) cap1.push_back(msg[1]);
            if (reset && wr[2] === 1'b1) cap2.push_back(msg[2]);
            if (busy[0] === 1'b1 && done[0] === 1'b0) run0++;
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!reset) begin
                    mode_m[i] = 0;
                end else if (mode_m[i] == 0) begin
                    if (start) begin
                        line_s[i] = fmt(i, value);
                        pos_m[i]  = 0;
                        mode_m[i] = 1;
                    end
                end else if (mode_m[i] == 1) begin
                    if (!full) begin
                        pos_m[i]++;
                        if (pos_m[i] == line_s[i].len()) mode_m[i] = 2;
                    end
                end else begin
                    mode_m[i] = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int b0, b1, b2, r0;

        chk("pin_fmt_def", (fmt(0, 32'hDEADBEEF) == "0xDEADBEEF\r\n") ? 1 : 0, 1);
        chk("pin_fmt_lc",  (fmt(1, 32'h0000000A) == "0x0000000a\r\n") ? 1 : 0, 1);
        chk("pin_fmt_b8",  (fmt(2, 32'h000000F0) == "F0") ? 1 : 0, 1);

        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Plain line, no back-pressure.
        b0 = cap0.size(); r0 = run0;
        pulse(32'hDEADBEEF);
        wait_idle(40);
        chk_str("t1_line", cap0, b0, "0xDEADBEEF\r\n");
        chk("t1_cycles", 32'(run0 - r0), 32'd12);

        // Stall for 5 cycles after the third byte.
        b0 = cap0.size(); r0 = run0;
        pulse(32'hDEADBEEF);
        repeat (3) @(negedge clk);
        full = 1'b1;
        #3;
        chk("t2_hold_msg", 32'(msg[0]), 32'h45);
        chk("t2_hold_wr", 32'(wr[0]), 32'd0);
        repeat (5) @(negedge clk);
        full = 1'b0;
        wait_idle(40);
        chk_str("t2_line", cap0, b0, "0xDEADBEEF\r\n");
        chk("t2_cycles", 32'(run0 - r0), 32'd17);

        // Lowercase with an ignored restart at byte 5.
        b1 = cap1.size();
        pulse(32'h0000000A);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(40);
        chk_str("t3_line", cap1, b1, "0x0000000a\r\n");

        // Bare 8-bit digits and done timing.
        b2 = cap2.size();
        pulse(32'h000000F0);
        repeat (2) @(negedge clk);
        #3;
        chk("t4_done", 32'(done[2]), 32'd1);
        wait_idle(40);
        chk_str("t4_line", cap2, b2, "F0");

        // Asynchronous reset while byte 6 is presented.
        b0 = cap0.size();
        pulse(32'hDEADBEEF);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5_wr", 32'(wr[0]), 32'd0);
        chk("t5_busy", 32'(busy[0]), 32'd0);
        chk("t5_done", 32'(done[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_partial", 32'(cap0.size() - b0), 32'd5);
        b0 = cap0.size();
        pulse(32'h12345678);
        wait_idle(40);
        chk_str("t5_line", cap0, b0, "0x12345678\r\n");

        // Value changes after acceptance have no effect.
        b0 = cap0.size();
        pulse(32'hCAFEF00D);
        value = 32'h0;
        wait_idle(40);
        chk_str("t6_line", cap0, b0, "0xCAFEF00D\r\n");

        // Randomised start/full/value traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            full  = ($urandom_range(0, 2) == 0);
            value = $urandom;
            if ($urandom_range(0, 149) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        full  = 1'b0;
        wait_idle(60);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
